chip8_pc_sequencer: RTL and testbench

//  Parametrised fetch/commit sequencer owning PC, call stack and instruction pacing for the Chip8 core.

---
 rtl/chip8_pc_sequencer_if.sv | 52 +++++
 rtl/chip8_pc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_chip8_pc_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pc_sequencer_if.sv
// chip8_pc_sequencer_if: host, memory-fetch and CPU handshake bundle for the PC sequencer.
//   host_we/host_sel/host_wdata : host register writes (0=PC 1=MODE 2=SP 3=reserved)
//   mem_addr_a/b, mem_rdata_a/b : two-port opcode fetch, 1-cycle read latency
//   instr/instr_valid/exec_stage: opcode hand-off to the CPU and EXEC cycle count
//   cpu_done/pc_src/pc_wdata/push/pop : CPU result, sampled when cpu_done is high
//   pc/sp/running/fault_ovf/fault_unf : sequencer status
// slave = sequencer side, master = system/host side.
interface chip8_pc_sequencer_if #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 16
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic              host_we;
    logic [1:0]        host_sel;
    logic [ADDR_W-1:0] host_wdata;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [7:0]        mem_rdata_a;
    logic [7:0]        mem_rdata_b;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [15:0]       exec_stage;
    logic              cpu_done;
    logic [1:0]        cpu_pc_src;
    logic [ADDR_W-1:0] cpu_pc_wdata;
    logic              cpu_push;
    logic              cpu_pop;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              running;
    logic              fault_ovf;
    logic              fault_unf;

    modport slave (
        input  host_we, host_sel, host_wdata,
        input  mem_rdata_a, mem_rdata_b,
        input  cpu_done, cpu_pc_src, cpu_pc_wdata, cpu_push, cpu_pop,
        output mem_addr_a, mem_addr_b,
        output instr, instr_valid, exec_stage,
        output pc, sp, running, fault_ovf, fault_unf
    );

    modport master (
        output host_we, host_sel, host_wdata,
        output mem_rdata_a, mem_rdata_b,
        output cpu_done, cpu_pc_src, cpu_pc_wdata, cpu_push, cpu_pop,
        input  mem_addr_a, mem_addr_b,
        input  instr, instr_valid, exec_stage,
        input  pc, sp, running, fault_ovf, fault_unf
    );
endinterface

// File: rtl/chip8_pc_sequencer.sv
// chip8_pc_sequencer: fetch/commit sequencer owning PC, call stack and instruction pacing.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : chip8_pc_sequencer_if.slave (host writes, opcode fetch, CPU hand-off, status)
// Flow: IDLE -> FETCH -> LATCH -> EXEC -> COMMIT -> PACE -> FETCH | IDLE.
// Modes: RUN, STEP (one instruction then PAUSE), PAUSE. Stack faults are sticky and
// halt at the next instruction boundary until the host writes MODE.
module chip8_pc_sequencer #(
    parameter int ADDR_W          = 12,
    parameter int STACK_DEPTH     = 16,
    parameter int TICKS_PER_INSTR = 50000,
    parameter int RESET_PC        = 'h200
) (
    input logic                 clk,
    input logic                 reset_n,
    chip8_pc_sequencer_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int PW   = $clog2(TICKS_PER_INSTR);
    localparam logic [PW-1:0]     PACE_LAST = PW'(TICKS_PER_INSTR - 1);
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_COMMIT, S_PACE
    } state_t;

    typedef enum logic [1:0] {
        M_RUN   = 2'd0,
        M_STEP  = 2'd1,
        M_PAUSE = 2'd2
    } mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [15:0]       instr_q, instr_d;
    logic              iv_q, iv_d;
    logic [15:0]       exec_q, exec_d;
    logic [PW-1:0]     pace_q, pace_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    // CPU result captured on the cpu_done cycle and consumed in COMMIT
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic [1:0]        src_q, src_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              host_mode_wr;
    logic              host_pc_wr;
    logic              host_sp_wr;
    logic              sp_full;
    logic              fault;
    logic              push_en;
    logic [SP_W-2:0]   top_idx;
    logic [ADDR_W-1:0] pc_next;
    logic [SP_W-1:0]   sp_clamp;

    assign host_mode_wr = bus.host_we && bus.host_sel == 2'd1 && bus.host_wdata[1:0] != 2'd3;
    assign host_pc_wr   = bus.host_we && bus.host_sel == 2'd0;
    assign host_sp_wr   = bus.host_we && bus.host_sel == 2'd2;
    assign sp_full      = sp_q == SP_FULL;
    assign fault        = ovf_q || unf_q;
    assign top_idx      = sp_q[SP_W-2:0] - 1'b1;
    assign pc_next      = pc_q + ADDR_W'(2);
    assign sp_clamp     = bus.host_wdata > ADDR_W'(STACK_DEPTH) ? SP_FULL : bus.host_wdata[SP_W-1:0];
    assign push_en      = state_q == S_COMMIT && push_q && !pop_q && !sp_full;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        instr_d = instr_q;
        iv_d    = 1'b0;
        exec_d  = exec_q;
        pace_d  = pace_q == PACE_LAST ? pace_q : pace_q + 1'b1;
        ovf_d   = host_mode_wr ? 1'b0 : ovf_q;
        unf_d   = host_mode_wr ? 1'b0 : unf_q;
        push_d  = push_q;
        pop_d   = pop_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        case (state_q)
            S_IDLE: begin
                state_d = (mode_q != M_PAUSE && !fault) ? S_FETCH : S_IDLE;
                pc_d    = host_pc_wr ? bus.host_wdata : pc_q;
                sp_d    = host_sp_wr ? sp_clamp : sp_q;
            end
            S_FETCH: begin
                // FETCH is cycle 0 of the pacing window, so the next cycle counts as 1
                state_d = S_LATCH;
                pace_d  = PW'(1);
                exec_d  = '0;
            end
            S_LATCH: begin
                state_d = S_EXEC;
                instr_d = {bus.mem_rdata_a, bus.mem_rdata_b};
                iv_d    = 1'b1;
            end
            S_EXEC: begin
                exec_d = exec_q == 16'hFFFF ? exec_q : exec_q + 16'd1;
                if (bus.cpu_done) begin
                    state_d = S_COMMIT;
                    push_d  = bus.cpu_push;
                    pop_d   = bus.cpu_pop;
                    src_d   = bus.cpu_pc_src;
                    tgt_d   = bus.cpu_pc_wdata;
                end
            end
            S_COMMIT: begin
                state_d = S_PACE;
                if (push_q && pop_q) begin
                    unf_d = 1'b1;
                end else if (push_q) begin
                    ovf_d = sp_full ? 1'b1 : ovf_d;
                    sp_d  = sp_full ? sp_q : sp_q + 1'b1;
                    pc_d  = sp_full ? pc_q : tgt_q;
                end else if (pop_q) begin
                    unf_d = sp_q == '0 ? 1'b1 : unf_d;
                    sp_d  = sp_q == '0 ? sp_q : sp_q - 1'b1;
                    pc_d  = sp_q == '0 ? pc_q : stack_q[top_idx];
                end else begin
                    pc_d = src_q == 2'd1 ? pc_q + ADDR_W'(4) :
                           src_q == 2'd2 ? tgt_q : pc_next;
                end
            end
            S_PACE: begin
                // pace saturates, so an EXEC that overran the budget exits here at once
                if (pace_q == PACE_LAST) begin
                    state_d = (fault || mode_q != M_RUN) ? S_IDLE : S_FETCH;
                    mode_d  = mode_q == M_STEP ? M_PAUSE : mode_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a host MODE write overrides the automatic STEP -> PAUSE transition
        if (host_mode_wr)
            mode_d = mode_t'(bus.host_wdata[1:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_PAUSE;
            pc_q    <= PC_RST;
            sp_q    <= '0;
            instr_q <= '0;
            iv_q    <= 1'b0;
            exec_q  <= '0;
            pace_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            src_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            instr_q <= instr_d;
            iv_q    <= iv_d;
            exec_q  <= exec_d;
            pace_q  <= pace_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
        end
    end

    // stack storage needs no reset; only entries below sp are ever read
    always_ff @(posedge clk) begin
        if (push_en)
            stack_q[sp_q[SP_W-2:0]] <= pc_next;
    end

    assign bus.mem_addr_a  = pc_q;
    assign bus.mem_addr_b  = pc_q + ADDR_W'(1);
    assign bus.instr       = instr_q;
    assign bus.instr_valid = iv_q;
    assign bus.exec_stage  = exec_q;
    assign bus.pc          = pc_q;
    assign bus.sp          = sp_q;
    assign bus.running     = state_q != S_IDLE;
    assign bus.fault_ovf   = ovf_q;
    assign bus.fault_unf   = unf_q;
endmodule

// File: tb/tb_chip8_pc_sequencer.sv
// tb_chip8_pc_sequencer: randomized self-checking bench for chip8_pc_sequencer against a behavioural model.
module tb_chip8_pc_sequencer;
    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int TICKS = 16;
    localparam int MASK  = 'hFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    chip8_pc_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus();

    chip8_pc_sequencer #(
        .ADDR_W(AW), .STACK_DEPTH(DEPTH), .TICKS_PER_INSTR(TICKS), .RESET_PC('h200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [7:0] mem [4096];
    always @(posedge clk) begin
        bus.mem_rdata_a <= mem[bus.mem_addr_a];
        bus.mem_rdata_b <= mem[bus.mem_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int pc_m, sp_m, mode_m;
    int stk_m [DEPTH];
    bit ovf_m, unf_m;
    int last_iv, last_e;
    bit chain;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(int sel, int data);
        bus.host_we    = 1'b1;
        bus.host_sel   = sel[1:0];
        bus.host_wdata = data[AW-1:0];
        tick();
        bus.host_we = 1'b0;
        if (sel == 1 && data[1:0] != 2'd3) begin
            mode_m = data & 3;
            ovf_m  = 0;
            unf_m  = 0;
        end
    endtask

    task automatic wait_idle(string tag);
        int k = 0;
        while (bus.running && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, 32'(bus.running), 0);
        chain = 0;
    endtask

    task automatic quiet(string tag);
        int n = 0;
        for (int i = 0; i < 3 * TICKS; i++) begin
            tick();
            if (bus.instr_valid) n++;
        end
        check({tag, "_quiet"}, n, 0);
        check({tag, "_still_idle"}, 32'(bus.running), 0);
    endtask

    // one instruction: wait for the opcode, answer after dly extra EXEC cycles, check the commit
    // hm: 0 none, 1 host PAUSE write during EXEC, 2 host PC write during EXEC (must be ignored)
    task automatic run_instr(bit push, bit pop, int src, int wd, int dly, int hm);
        int k = 0;
        int e;
        while (!bus.instr_valid && k < 300) begin
            tick();
            k++;
        end
        check("iv_seen", 32'(bus.instr_valid), 1);
        if (!bus.instr_valid) return;
        if (chain)
            check("fetch_interval", cyc - last_iv, (last_e + 4 > TICKS) ? last_e + 4 : TICKS);
        last_iv = cyc;
        check("instr", 32'(bus.instr), {16'h0, mem[pc_m], mem[(pc_m + 1) & MASK]});
        e = dly + 1;
        if (hm == 1) host_write(1, 2);
        if (hm == 2) host_write(0, int'($urandom_range(0, MASK)));
        for (int i = (hm != 0) ? 1 : 0; i < dly; i++) tick();
        bus.cpu_done     = 1'b1;
        bus.cpu_push     = push;
        bus.cpu_pop      = pop;
        bus.cpu_pc_src   = src[1:0];
        bus.cpu_pc_wdata = wd[AW-1:0];
        tick();
        bus.cpu_done = 1'b0;
        bus.cpu_push = 1'b0;
        bus.cpu_pop  = 1'b0;
        tick();
        if (push && pop) unf_m = 1;
        else if (push) begin
            if (sp_m == DEPTH) ovf_m = 1;
            else begin
                stk_m[sp_m] = (pc_m + 2) & MASK;
                sp_m++;
                pc_m = wd & MASK;
            end
        end else if (pop) begin
            if (sp_m == 0) unf_m = 1;
            else begin
                sp_m--;
                pc_m = stk_m[sp_m];
            end
        end else
            pc_m = (src == 1) ? (pc_m + 4) & MASK : (src == 2) ? wd & MASK : (pc_m + 2) & MASK;
        check("pc", 32'(bus.pc), pc_m);
        check("sp", 32'(bus.sp), sp_m);
        check("fault_ovf", 32'(bus.fault_ovf), 32'(ovf_m));
        check("fault_unf", 32'(bus.fault_unf), 32'(unf_m));
        check("exec_stage", 32'(bus.exec_stage), e);
        check("running_pace", 32'(bus.running), 1);
        last_e = e;
        if (mode_m == 1) mode_m = 2;
        chain = (mode_m == 0) && !ovf_m && !unf_m && hm != 1;
    endtask

    initial begin
        bus.host_we = 0; bus.host_sel = 0; bus.host_wdata = 0;
        bus.cpu_done = 0; bus.cpu_pc_src = 0; bus.cpu_pc_wdata = 0;
        bus.cpu_push = 0; bus.cpu_pop = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        pc_m = 'h200; sp_m = 0; mode_m = 2; ovf_m = 0; unf_m = 0;
        chain = 0; last_iv = 0; last_e = 0;
        for (int i = 0; i < DEPTH; i++) stk_m[i] = 0;

        repeat (3) tick();
        check("rst_pc", 32'(bus.pc), 'h200);
        check("rst_sp", 32'(bus.sp), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_instr", 32'(bus.instr), 0);
        check("rst_iv", 32'(bus.instr_valid), 0);
        check("rst_exec", 32'(bus.exec_stage), 0);
        check("rst_faults", {30'h0, bus.fault_ovf, bus.fault_unf}, 0);
        check("rst_addr_b", 32'(bus.mem_addr_b), 'h201);
        reset_n = 1'b1;
        quiet("paused");

        mem['h200] = 8'h00;
        mem['h201] = 8'hE0;
        host_write(1, 0);
        run_instr(0, 0, 0, 0, 1, 0);
        check("first_instr", 32'(bus.instr), 'h00E0);
        run_instr(0, 0, 0, 0, 0, 0);
        run_instr(1, 0, 0, 'h300, 2, 0);
        run_instr(0, 1, 0, 0, 0, 0);
        check("ret_pc", 32'(bus.pc), 'h206);
        run_instr(0, 0, 0, 0, 14, 0);
        run_instr(0, 0, 1, 0, 0, 0);
        run_instr(0, 0, 2, 'h5A4, 1, 2);
        run_instr(0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int r = int'($urandom_range(0, 99));
            int d = int'($urandom_range(0, 4));
            run_instr(r < 15 || (r >= 30 && r < 35), r >= 15 && r < 35,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                      d, (d > 0 && $urandom_range(0, 9) == 0) ? 2 : 0);
            if (ovf_m || unf_m) begin
                wait_idle("fault");
                host_write(1, 0);
                check("fault_clr", {30'h0, bus.fault_ovf, bus.fault_unf}, 0);
            end
        end

        run_instr(0, 0, 0, 0, 2, 1);
        wait_idle("pause");
        quiet("pause");

        host_write(2, 31);
        sp_m = DEPTH;
        check("sp_clamp", 32'(bus.sp), DEPTH);
        host_write(2, 0);
        sp_m = 0;
        check("sp_write", 32'(bus.sp), 0);
        host_write(1, 0);
        for (int i = 0; i < DEPTH + 1; i++)
            run_instr(1, 0, 0, int'($urandom_range(0, MASK)), 0, 0);
        check("ovf_sp", 32'(bus.sp), DEPTH);
        check("ovf_flag", 32'(bus.fault_ovf), 1);
        wait_idle("ovf");

        host_write(0, 'h3FE);
        pc_m = 'h3FE;
        check("host_pc", 32'(bus.pc), 'h3FE);
        host_write(1, 1);
        check("mode_clr_ovf", 32'(bus.fault_ovf), 0);
        run_instr(0, 0, 0, 0, 0, 0);
        check("step_instr", 32'(bus.instr), {16'h0, mem['h3FE], mem['h3FF]});
        wait_idle("step");
        quiet("step");

        host_write(0, 'hFFF);
        pc_m = 'hFFF;
        check("addr_b_wrap", 32'(bus.mem_addr_b), 0);
        host_write(0, 'hFFE);
        pc_m = 'hFFE;
        host_write(1, 0);
        run_instr(0, 0, 1, 0, 0, 0);
        check("skip_wrap", 32'(bus.pc), 'h002);

        run_instr(1, 1, 0, 'h123, 0, 0);
        check("pushpop_unf", 32'(bus.fault_unf), 1);
        wait_idle("pushpop");
        host_write(2, 0);
        sp_m = 0;
        host_write(1, 0);
        run_instr(0, 1, 0, 0, 1, 0);
        check("pop_empty_unf", 32'(bus.fault_unf), 1);
        wait_idle("pop_empty");

        host_write(1, 0);
        begin
            int k = 0;
            while (!bus.instr_valid && k < 300) begin
                tick();
                k++;
            end
            check("pre_reset_iv", 32'(bus.instr_valid), 1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_running", 32'(bus.running), 0);
        check("async_rst_pc", 32'(bus.pc), 'h200);
        check("async_rst_iv", 32'(bus.instr_valid), 0);
        tick();
        reset_n = 1'b1;
        quiet("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
